register_file_sb: RTL

- Parametrised, clocked successor of the 8x32 register array: NUM_REGS = 2**BITS_ADDR registers of BITS_DATA bits.
- One write port and two read ports.
- Read-after-write bypass, an optional hard-wired zero register, and a per-register busy scoreboard so the issue logic can detect pending writebacks.
- Sits between decode (reads, reservations) and writeback (writes) in the CPU datapath.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/register_scoreboard.sv | 47 ++++
 rtl/register_file_sb.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing defaults and helpers for the register file and its busy scoreboard.
package regfile_pkg;

    localparam int unsigned DEFAULT_BITS_DATA = 32'd32;
    localparam int unsigned DEFAULT_BITS_ADDR = 32'd3;
    localparam int unsigned ZERO_ADDR         = 32'd0;

    function automatic int unsigned numRegs(input int unsigned bitsAddr);
        return 32'd1 << bitsAddr;
    endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Per-register busy bits: set by a reservation, cleared by the matching writeback.
module register_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned BITS_ADDR = DEFAULT_BITS_ADDR,
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic                            writeEnable,
    input  logic [BITS_ADDR-1:0]            dirrInput,
    input  logic                            reserveEnable,
    input  logic [BITS_ADDR-1:0]            dirrReserve,
    output logic [numRegs(BITS_ADDR)-1:0]   busyVector
);

    localparam int unsigned NUM_REGS = numRegs(BITS_ADDR);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] clearMask_s;
    logic [NUM_REGS-1:0] setMask_s;
    logic [NUM_REGS-1:0] nextBusy_s;

    // Decode write/reserve addresses; set is applied after clear so a new producer wins.
    always_comb begin
        clearMask_s = {NUM_REGS{1'b0}};
        setMask_s   = {NUM_REGS{1'b0}};
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            clearMask_s[i] = writeEnable && (dirrInput == BITS_ADDR'(i));
            setMask_s[i]   = reserveEnable && (dirrReserve == BITS_ADDR'(i))
                             && !(ZERO_REG && (i == ZERO_ADDR));
        end
        nextBusy_s = (busy_r & ~clearMask_s) | setMask_s;
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= nextBusy_s;
        end
    end

    assign busyVector = busy_r;

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file: one write port, two combinational read ports with
// write bypass, optional hard-wired zero register and a busy scoreboard.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned BITS_DATA = DEFAULT_BITS_DATA,
    parameter int unsigned BITS_ADDR = DEFAULT_BITS_ADDR,
    parameter bit          ZERO_REG  = 1'b1,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic                            writeEnable,
    input  logic [BITS_ADDR-1:0]            dirrInput,
    input  logic [BITS_DATA-1:0]            inputData,
    input  logic [BITS_ADDR-1:0]            dirrOutput1,
    input  logic [BITS_ADDR-1:0]            dirrOutput2,
    output logic [BITS_DATA-1:0]            outputData1,
    output logic [BITS_DATA-1:0]            outputData2,
    output logic                            outputReady1,
    output logic                            outputReady2,
    input  logic                            reserveEnable,
    input  logic [BITS_ADDR-1:0]            dirrReserve,
    output logic [numRegs(BITS_ADDR)-1:0]   busyVector
);

    localparam int unsigned          NUM_REGS = numRegs(BITS_ADDR);
    localparam logic [BITS_ADDR-1:0] zeroAddr = BITS_ADDR'(ZERO_ADDR);

    logic [BITS_DATA-1:0] regArray_r [NUM_REGS];
    logic                 writeAllowed_s;
    logic                 isZero1_s;
    logic                 isZero2_s;
    logic                 hit1_s;
    logic                 hit2_s;

    assign writeAllowed_s = writeEnable && !(ZERO_REG && (dirrInput == zeroAddr));
    assign isZero1_s      = ZERO_REG && (dirrOutput1 == zeroAddr);
    assign isZero2_s      = ZERO_REG && (dirrOutput2 == zeroAddr);
    assign hit1_s         = BYPASS && writeEnable && (dirrInput == dirrOutput1);
    assign hit2_s         = BYPASS && writeEnable && (dirrInput == dirrOutput2);

    // Storage array: one write per cycle, cleared asynchronously.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regArray_r[i] <= {BITS_DATA{1'b0}};
            end
        end else if (writeAllowed_s) begin
            regArray_r[dirrInput] <= inputData;
        end
    end

    register_scoreboard #(
        .BITS_ADDR (BITS_ADDR),
        .ZERO_REG  (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .rstN          (rstN),
        .writeEnable   (writeEnable),
        .dirrInput     (dirrInput),
        .reserveEnable (reserveEnable),
        .dirrReserve   (dirrReserve),
        .busyVector    (busyVector)
    );

    // Read port 1; bypass is masked in reset so the port holds 0 there.
    always_comb begin
        outputData1  = {BITS_DATA{1'b0}};
        outputReady1 = 1'b1;
        if (!rstN) begin
            outputData1  = {BITS_DATA{1'b0}};
            outputReady1 = 1'b1;
        end else if (isZero1_s) begin
            outputData1  = {BITS_DATA{1'b0}};
            outputReady1 = 1'b1;
        end else if (hit1_s) begin
            outputData1  = inputData;
            outputReady1 = 1'b1;
        end else begin
            outputData1  = regArray_r[dirrOutput1];
            outputReady1 = !busyVector[dirrOutput1];
        end
    end

    // Read port 2, same priority as port 1.
    always_comb begin
        outputData2  = {BITS_DATA{1'b0}};
        outputReady2 = 1'b1;
        if (!rstN) begin
            outputData2  = {BITS_DATA{1'b0}};
            outputReady2 = 1'b1;
        end else if (isZero2_s) begin
            outputData2  = {BITS_DATA{1'b0}};
            outputReady2 = 1'b1;
        end else if (hit2_s) begin
            outputData2  = inputData;
            outputReady2 = 1'b1;
        end else begin
            outputData2  = regArray_r[dirrOutput2];
            outputReady2 = !busyVector[dirrOutput2];
        end
    end

endmodule
